// File: rtl/board_write_sched.sv
// Board RAM write scheduler: round-robin arbitration between sprite
// requesters, each granted move erases the old block then draws the new one.
module board_write_sched #(
  parameter int                NREQ       = 4,
  parameter int                ADDR_W     = 10,
  parameter int                DATA_W     = 4,
  parameter logic [DATA_W-1:0] ERASE_CODE = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hold,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_old_addr,
  input  logic [NREQ*ADDR_W-1:0] req_new_addr,
  input  logic [NREQ*DATA_W-1:0] req_code,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        req_done,
  output logic                   wren,
  output logic [ADDR_W-1:0]      write_addr,
  output logic [DATA_W-1:0]      write_data,
  output logic                   busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, DONE} state_t;

  state_t            state, state_nx;
  logic [PTR_W-1:0]  rr_ptr, rr_ptr_nx;
  logic [PTR_W-1:0]  win, win_nx;
  logic [ADDR_W-1:0] old_q, old_nx, new_q, new_nx;
  logic [DATA_W-1:0] code_q, code_nx;

  logic              grant_found;
  logic [PTR_W-1:0]  grant_idx;
  logic [ADDR_W-1:0] old_sel, new_sel;
  logic [DATA_W-1:0] code_sel;

  logic [NREQ-1:0]   ready_nx, done_nx;
  logic              wren_nx, busy_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] data_nx;

  // Round-robin search: first valid requester at or after rr_ptr, explicit wrap at NREQ-1.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < unsigned'(NREQ); k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= unsigned'(NREQ)) idx = idx - unsigned'(NREQ);
      if (!grant_found && req_valid[PTR_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

  // Select the winning requester's address and code slices.
  always_comb begin
    old_sel  = '0;
    new_sel  = '0;
    code_sel = '0;
    for (int unsigned i = 0; i < unsigned'(NREQ); i++) begin
      if (grant_idx == PTR_W'(i)) begin
        old_sel  = req_old_addr[i*ADDR_W +: ADDR_W];
        new_sel  = req_new_addr[i*ADDR_W +: ADDR_W];
        code_sel = req_code[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next state and next output values; outputs show the action of the state just left,
  // so the registered write lands one edge after the state is entered.
  always_comb begin
    state_nx  = state;
    rr_ptr_nx = rr_ptr;
    win_nx    = win;
    old_nx    = old_q;
    new_nx    = new_q;
    code_nx   = code_q;
    ready_nx  = '0;
    done_nx   = '0;
    wren_nx   = 1'b0;
    addr_nx   = '0;
    data_nx   = '0;
    case (state)
      IDLE: begin
        if (!hold && grant_found) begin
          win_nx   = grant_idx;
          old_nx   = old_sel;
          new_nx   = new_sel;
          code_nx  = code_sel;
          ready_nx = NREQ'(1) << grant_idx;
          state_nx = (old_sel != new_sel) ? CLEAR : DRAW;
        end
      end
      CLEAR: begin
        wren_nx  = 1'b1;
        addr_nx  = old_q;
        data_nx  = ERASE_CODE;
        state_nx = DRAW;
      end
      DRAW: begin
        wren_nx  = 1'b1;
        addr_nx  = new_q;
        data_nx  = code_q;
        state_nx = DONE;
      end
      DONE: begin
        done_nx   = NREQ'(1) << win;
        rr_ptr_nx = (win == PTR_W'(NREQ - 1)) ? '0 : win + 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Latched move, arbitration pointer and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= '0;
      win        <= '0;
      old_q      <= '0;
      new_q      <= '0;
      code_q     <= '0;
      req_ready  <= '0;
      req_done   <= '0;
      wren       <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      busy       <= 1'b0;
    end else begin
      rr_ptr     <= rr_ptr_nx;
      win        <= win_nx;
      old_q      <= old_nx;
      new_q      <= new_nx;
      code_q     <= code_nx;
      req_ready  <= ready_nx;
      req_done   <= done_nx;
      wren       <= wren_nx;
      write_addr <= addr_nx;
      write_data <= data_nx;
      busy       <= busy_nx;
    end
  end

endmodule

// File: tb/tb_board_write_sched.sv
// Scoreboard bench for board_write_sched: stimulus queues expected ready /
// write / done events with their cycle numbers, a monitor checks each output.
module tb_board_write_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        hold;
  logic [3:0]  req_valid;
  logic [39:0] req_old_addr;
  logic [39:0] req_new_addr;
  logic [15:0] req_code;
  logic [3:0]  req_ready;
  logic [3:0]  req_done;
  logic        wren;
  logic [9:0]  write_addr;
  logic [3:0]  write_data;
  logic        busy;

  board_write_sched #(.NREQ(4), .ADDR_W(10), .DATA_W(4), .ERASE_CODE(4'b0000)) dut (
    .clk(clk), .reset(reset), .hold(hold), .req_valid(req_valid),
    .req_old_addr(req_old_addr), .req_new_addr(req_new_addr), .req_code(req_code),
    .req_ready(req_ready), .req_done(req_done), .wren(wren),
    .write_addr(write_addr), .write_data(write_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int kind;   // 0 ready, 1 write, 2 done
    int idx;
    int addr;
    int data;
  } ev_t;

  ev_t q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic push(input int c, input int k, input int i, input int a, input int d);
    ev_t e;
    e.cyc = c; e.kind = k; e.idx = i; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  task automatic push_move(input int t, input int i, input int old, input int nw, input int code);
    push(t, 0, i, 0, 0);
    if (old != nw) begin
      push(t + 1, 1, 0, old, 0);
      push(t + 2, 1, 0, nw, code);
      push(t + 3, 2, i, 0, 0);
    end else begin
      push(t + 1, 1, 0, nw, code);
      push(t + 2, 2, i, 0, 0);
    end
  endtask

  task automatic set_req(input int i, input bit v, input int old, input int nw, input int code);
    req_valid[i]             = v;
    req_old_addr[i*10 +: 10] = old[9:0];
    req_new_addr[i*10 +: 10] = nw[9:0];
    req_code[i*4 +: 4]       = code[3:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic check(input string name, input int got, input int req);
    total++;
    if (got != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Monitor: flag missed events, then compare any presented output against the queue head.
  always @(negedge clk) begin
    ev_t e;
    logic [3:0] er, ed;
    logic       ew;
    if (reset === 1'b1) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        total++;
        bad++;
        $display("FAIL missed_event kind=%0d idx=%0d: nothing seen, required at cyc %0d", e.kind, e.idx, e.cyc);
      end
      if (req_ready != 4'b0 || wren || req_done != 4'b0) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output cyc=%0d: got ready=%b done=%b wren=%b addr=%0d data=%0d, required no output",
                   cyc, req_ready, req_done, wren, write_addr, write_data);
        end else begin
          e  = q.pop_front();
          er = (e.kind == 0) ? (4'b0001 << e.idx) : 4'b0000;
          ed = (e.kind == 2) ? (4'b0001 << e.idx) : 4'b0000;
          ew = (e.kind == 1);
          if (cyc != e.cyc || req_ready != er || req_done != ed || wren != ew ||
              (ew && (32'(write_addr) != e.addr || 32'(write_data) != e.data))) begin
            bad++;
            $display("FAIL event_kind%0d cyc=%0d: got ready=%b done=%b wren=%b addr=%0d data=%0d, required cyc=%0d ready=%b done=%b wren=%b addr=%0d data=%0d",
                     e.kind, cyc, req_ready, req_done, wren, write_addr, write_data,
                     e.cyc, er, ed, ew, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset        = 1'b1;
    hold         = 1'b0;
    req_valid    = '0;
    req_old_addr = '0;
    req_new_addr = '0;
    req_code     = '0;
    #2 reset = 1'b0;
    steps(2);

    // Reset values
    check("rst_wren",  32'(wren), 0);
    check("rst_addr",  32'(write_addr), 0);
    check("rst_data",  32'(write_data), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_done",  32'(req_done), 0);
    check("rst_busy",  32'(busy), 0);
    reset = 1'b1;
    step();

    // Single move 495 -> 496, code 3, requester 0
    set_req(0, 1'b1, 495, 496, 3);
    t = cyc + 1;
    push_move(t, 0, 495, 496, 3);
    step();
    check("busy_after_accept", 32'(busy), 1);
    set_req(0, 1'b0, 0, 0, 0);
    steps(5);

    // Same-block move on requester 1: no erase write
    set_req(1, 1'b1, 100, 100, 3);
    t = cyc + 1;
    push_move(t, 1, 100, 100, 3);
    step();
    set_req(1, 1'b0, 0, 0, 0);
    steps(5);

    // Fairness after a fresh reset: all four held high, order 0,1,2,3,0,1
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 200 + i, 300 + i, 4 + i);
    t = cyc + 1;
    for (int j = 0; j < 6; j++) push_move(t + 4*j, j % 4, 200 + (j % 4), 300 + (j % 4), 4 + (j % 4));
    steps(21);
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 0, 0, 0);
    steps(6);

    // Hold blocks grants for 10 cycles, then requester 2 wins on the next edge
    hold = 1'b1;
    set_req(2, 1'b1, 50, 51, 7);
    steps(10);
    check("hold_busy", 32'(busy), 0);
    hold = 1'b0;
    t = cyc + 1;
    push_move(t, 2, 50, 51, 7);
    step();
    set_req(2, 1'b0, 0, 0, 0);
    steps(5);

    // Inputs changed after accept plus hold raised mid-move: move unaffected, no regrant
    set_req(3, 1'b1, 495, 496, 5);
    t = cyc + 1;
    push_move(t, 3, 495, 496, 5);
    step();
    set_req(3, 1'b1, 11, 10, 9);
    hold = 1'b1;
    steps(8);
    set_req(3, 1'b0, 0, 0, 0);
    hold = 1'b0;
    step();

    // Move on requester 1 so the pointer sits at 2
    set_req(1, 1'b1, 60, 61, 2);
    t = cyc + 1;
    push_move(t, 1, 60, 61, 2);
    step();
    set_req(1, 1'b0, 0, 0, 0);
    steps(5);

    // Reset during DRAW: the erase write is seen, nothing after it
    set_req(2, 1'b1, 70, 71, 6);
    t = cyc + 1;
    push(t, 0, 2, 0, 0);
    push(t + 1, 1, 0, 70, 0);
    step();
    set_req(2, 1'b0, 0, 0, 0);
    step();
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_wren", 32'(wren), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(req_done), 0);
    steps(2);

    // After release the pointer is back at 0: requester 1 beats requester 3
    reset = 1'b1;
    set_req(1, 1'b1, 80, 81, 1);
    set_req(3, 1'b1, 90, 91, 8);
    t = cyc + 1;
    push_move(t, 1, 80, 81, 1);
    push_move(t + 4, 3, 90, 91, 8);
    step();
    set_req(1, 1'b0, 0, 0, 0);
    steps(4);
    set_req(3, 1'b0, 0, 0, 0);
    steps(6);

    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/board_write_sched.md
BOARD_WRITE_SCHED -- requirements
Module: board_write_sched

Interface
REQ-001 Parameter NREQ, default 4, number of sprite requesters (pac-man plus ghosts), range 2..8.
REQ-002 Parameter ADDR_W, default 10, board RAM block address width (768 blocks).
REQ-003 Parameter DATA_W, default 4, block type code width.
REQ-004 Parameter ERASE_CODE, default 4'b0000, block type written when a sprite leaves a block.
REQ-005 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-006 Port: reset  input  1  asynchronous active-low reset.
REQ-007 Port: hold  input  1  when high, no new request is granted; an in-flight move completes.
REQ-008 Port: req_valid  input  NREQ  per-requester move request, held until accepted.
REQ-009 Port: req_old_addr  input  NREQ*ADDR_W  per-requester current block; requester i occupies slice [i*ADDR_W +: ADDR_W].
REQ-010 Port: req_new_addr  input  NREQ*ADDR_W  per-requester destination block, same slicing.
REQ-011 Port: req_code  input  NREQ*DATA_W  per-requester sprite block type, slice [i*DATA_W +: DATA_W].
REQ-012 Port: req_ready  output  NREQ  one-hot, one-cycle pulse marking acceptance of requester i.
REQ-013 Port: req_done  output  NREQ  one-hot, one-cycle pulse marking completion of requester i's move.
REQ-014 Port: wren  output  1  board RAM write enable.
REQ-015 Port: write_addr  output  ADDR_W  board RAM write address.
REQ-016 Port: write_data  output  DATA_W  board RAM write data.
REQ-017 Port: busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have the states IDLE, CLEAR, DRAW and DONE.
REQ-019 IDLE: if hold is low and any req_valid is high, the block SHALL grant the first valid requester at or after rr_ptr, searching upward with wrap from NREQ-1 to 0.
REQ-020 On a grant, the block SHALL latch the winner index, old address, new address and code, and SHALL pulse req_ready[winner] in the same edge's output.
REQ-021 IDLE -> CLEAR when the latched old address differs from the new address; IDLE -> DRAW when they are equal, so the CLEAR write is skipped.
REQ-022 CLEAR: wren=1, write_addr=latched old address, write_data=ERASE_CODE; next state is DRAW.
REQ-023 DRAW: wren=1, write_addr=latched new address, write_data=latched code; next state is DONE.
REQ-024 DONE: wren=0 and req_done[winner]=1 for exactly one cycle; rr_ptr SHALL become (winner+1) mod NREQ; next state is IDLE.
REQ-025 All outputs SHALL be registered; wren SHALL be 0 in IDLE and DONE.
REQ-026 Latency, measured from the accept edge T: the CLEAR write is presented at T+1, the DRAW write at T+2, and req_done at T+3; the first new grant is possible at T+4.
REQ-027 Inputs SHALL be ignored outside IDLE; changes to req_* after acceptance SHALL NOT affect the move in flight.
REQ-028 If hold rises mid-move, the move SHALL complete normally; while hold is high, the block SHALL remain in IDLE.
REQ-029 A requester whose req_valid stays high after req_done SHALL be eligible again, but only after higher-priority rotation order.
REQ-030 The block SHALL perform no collision checking; two moves to the same block are serialized in grant order, and the last DRAW wins.
REQ-031 rr_ptr SHALL be ceil(log2(NREQ)) bits wide; when NREQ is not a power of 2, wrap SHALL be explicit at NREQ-1 -> 0.

Reset
REQ-032 While reset is low: state=IDLE, rr_ptr=0, wren=0, write_addr=0, write_data=0, req_ready=0, req_done=0, busy=0.
REQ-033 A reset assertion mid-move SHALL abort the move immediately with no further write, and no req_done SHALL be issued for it.
REQ-034 After reset is released, the first grant SHALL occur no earlier than the first rising clk edge with reset high.

Verification
REQ-035 Single move: req_valid[0]=1, old=495, new=496, code=3 -> ready[0] at T; write (495,0) at T+1; write (496,3) at T+2; done[0] at T+3.
REQ-036 Same-block move: old=new=100, code=3 on requester 1 -> no CLEAR write; single write (100,3) at T+1; done[1] at T+2.
REQ-037 Fairness: all four req_valid held high continuously -> grant order 0,1,2,3,0,1 with exactly 4 cycles per move when CLEAR is not skipped.
REQ-038 Hold: hold=1 with req_valid[2]=1 -> no grant for 10 cycles; hold dropped -> grant to requester 2 on the next edge.
REQ-039 Reset mid-move: reset pulled low in the DRAW state -> wren=0 immediately, no done pulse, rr_ptr=0; a request after release is granted from index 0.
REQ-040 Input change after accept: new address changed from 496 to 10 at T+1 -> DRAW write still targets 496.
